// File: rtl/ram_sp_param_pkg.sv
// Shared types and helpers for the parametrised single-port RAM.
// The parity helper is only used when RAM_SP_PARAM_PARITY_EN is defined.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ramState_e;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 7;

  // Callers zero-extend their word into this width; extra zeros leave parity unchanged.
  localparam int PARITY_MAX_W = 1024;

  function automatic logic evenParity(input logic [PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ram_sp_param_if.sv
// Request/response bundle for ram_sp_param: requests from master, read data and status from slave.
interface ram_sp_param_if import ram_pkg::*; #(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic              r;
  logic              w;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] D;
  logic [DATA_W-1:0] o;
  logic              rvalid;
  logic              busy;
  logic              perr;

  modport master (
    output r, w, addr, D,
    input  o, rvalid, busy, perr
  );

  modport slave (
    input  r, w, addr, D,
    output o, rvalid, busy, perr
  );

endinterface

// File: rtl/ram_sp_param_clear_seq.sv
// Clear sequencer: after reset, sweeps every address once with a write enable,
// then parks in READY until the next reset.
module ram_clear_seq import ram_pkg::*; #(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy_o,
  output logic              clrWe_o,
  output logic [ADDR_W-1:0] clrAddr_o
);

  ramState_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_o  = 1'b0;
    clrWe_o = 1'b0;
    case (state_q)
      CLEAR: begin
        busy_o  = 1'b1;
        clrWe_o = 1'b1;
        ptr_d   = ptr_q + 1'b1;
        // The pointer wraps to zero here, which is harmless because READY never reads it.
        if (ptr_q == '1) begin
          state_d = READY;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  assign clrAddr_o = ptr_q;

endmodule

// File: rtl/ram_sp_param.sv
// Parametrised single-port RAM with post-reset hardware clear and registered read.
// Define RAM_SP_PARAM_PARITY_EN to store an even-parity bit per word and report perr on reads.
module ram_sp_param import ram_pkg::*; #(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input logic           clk,
  input logic           rst,
  ram_sp_param_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef RAM_SP_PARAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0]  mem [DEPTH];

  logic              busy;
  logic              clrWe;
  logic [ADDR_W-1:0] clrAddr;

  logic              we;
  logic              rdEn;
  logic [ADDR_W-1:0] wAddr;
  logic [MEM_W-1:0]  wWord;
  logic [MEM_W-1:0]  rWord;

  logic [DATA_W-1:0] o_q, o_d;
  logic              rvalid_q, rvalid_d;

  ram_clear_seq #(.ADDR_W(ADDR_W)) u_clearSeq (
    .clk       (clk),
    .rst       (rst),
    .busy_o    (busy),
    .clrWe_o   (clrWe),
    .clrAddr_o (clrAddr)
  );

`ifdef RAM_SP_PARAM_PARITY_EN
  logic [PARITY_MAX_W-1:0] wExt;
  logic [PARITY_MAX_W-1:0] rExt;
  logic                    perr_q, perr_d;
`endif

  // While busy the sequencer owns the write port and user requests are dropped.
  always_comb begin
    rdEn = bus.r && !busy;
`ifdef RAM_SP_PARAM_PARITY_EN
    wExt = '0;
    wExt[DATA_W-1:0] = bus.D;
`endif
    if (busy) begin
      we    = clrWe;
      wAddr = clrAddr;
      wWord = '0;
    end else begin
      we    = bus.w;
      wAddr = bus.addr;
`ifdef RAM_SP_PARAM_PARITY_EN
      wWord = {evenParity(wExt), bus.D};
`else
      wWord = bus.D;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wAddr] <= wWord;
    end
  end

  assign rWord = mem[bus.addr];

  always_comb begin
    o_d      = rdEn ? rWord[DATA_W-1:0] : o_q;
    rvalid_d = rdEn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q      <= '0;
      rvalid_q <= 1'b0;
    end else begin
      o_q      <= o_d;
      rvalid_q <= rvalid_d;
    end
  end

`ifdef RAM_SP_PARAM_PARITY_EN
  always_comb begin
    rExt = '0;
    rExt[DATA_W-1:0] = rWord[DATA_W-1:0];
    perr_d = rdEn && (rWord[DATA_W] != evenParity(rExt));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign bus.perr = perr_q;
`else
  assign bus.perr = 1'b0;
`endif

  assign bus.o      = o_q;
  assign bus.rvalid = rvalid_q;
  assign bus.busy   = busy;

endmodule

// File: tb/tb_ram_sp_param.sv
// Self-checking bench for ram_sp_param: directed clear/collision steps plus a randomized
// phase checked against an array model. Parity steps run when RAM_SP_PARAM_PARITY_EN is defined.
module tb_ram_sp_param;
  import ram_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 7;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] refMem [DEPTH];
  logic [DW-1:0] lastO;
  logic          expRvalid;

  ram_sp_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ram_sp_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: observed still running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      $error("[TB] check %s failed", tag);
    end
  endtask

  // One clock of stimulus; the model then updates using read-before-write order.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.r    = rd;
    bus.w    = wr;
    bus.addr = a;
    bus.D    = d;
    @(posedge clk);
    #1;
    if (rd) lastO = refMem[a];
    expRvalid = rd;
    if (wr) refMem[a] = d;
    bus.r = 1'b0;
    bus.w = 1'b0;
  endtask

  task automatic checkCycle(input string tag);
    checkOutput({tag, "_o"}, 32'(bus.o), 32'(lastO));
    checkOutput({tag, "_rvalid"}, 32'(bus.rvalid), 32'(expRvalid));
    checkOutput({tag, "_perr"}, 32'(bus.perr), 32'd0);
  endtask

  // Leaves whatever request is on the bus in place, so requests during clear are exercised.
  task automatic waitClear(input string tag);
    int   cnt;
    logic sawRvalid;
    logic sawO;
    cnt = 0;
    sawRvalid = 1'b0;
    sawO = 1'b0;
    rst = 1'b0;
    while (bus.busy === 1'b1 && cnt < 4 * DEPTH) begin
      sawRvalid = sawRvalid | bus.rvalid;
      sawO = sawO | (bus.o != '0);
      @(posedge clk);
      #1;
      cnt++;
    end
    checkOutput({tag, "_busyCycles"}, 32'(cnt), 32'(DEPTH));
    checkOutput({tag, "_rvalidDuringClear"}, 32'(sawRvalid), 32'd0);
    checkOutput({tag, "_oDuringClear"}, 32'(sawO), 32'd0);
    for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
    lastO = '0;
    expRvalid = 1'b0;
    bus.r = 1'b0;
    bus.w = 1'b0;
  endtask

  initial begin
    bus.r = 1'b0;
    bus.w = 1'b0;
    bus.addr = '0;
    bus.D = '0;
    lastO = '0;
    expRvalid = 1'b0;
    for (int i = 0; i < DEPTH; i++) refMem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(bus.busy), 32'd1);
    checkOutput("rst_rvalid", 32'(bus.rvalid), 32'd0);
    checkOutput("rst_o", 32'(bus.o), 32'd0);
    checkOutput("rst_perr", 32'(bus.perr), 32'd0);

    // Requests held on the bus throughout the first clear must be ignored.
    bus.r = 1'b1;
    bus.w = 1'b1;
    bus.addr = 7'd5;
    bus.D = 16'hFFFF;
    waitClear("clear1");

    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b1, 1'b0, AW'(a), '0);
      checkOutput("readAll_o", 32'(bus.o), 32'd0);
      checkOutput("readAll_rvalid", 32'(bus.rvalid), 32'd1);
    end

    applyStimulus(1'b0, 1'b1, 7'd60, 16'd256);
    applyStimulus(1'b0, 1'b1, 7'd45, 16'd64);
    applyStimulus(1'b1, 1'b0, 7'd60, '0);
    checkOutput("rd60_o", 32'(bus.o), 32'd256);
    checkOutput("rd60_rvalid", 32'(bus.rvalid), 32'd1);
    applyStimulus(1'b1, 1'b0, 7'd45, '0);
    checkOutput("rd45_o", 32'(bus.o), 32'd64);
    checkOutput("rd45_rvalid", 32'(bus.rvalid), 32'd1);

    applyStimulus(1'b0, 1'b0, 7'd60, '0);
    checkOutput("idle_oHold", 32'(bus.o), 32'd64);
    checkOutput("idle_rvalid", 32'(bus.rvalid), 32'd0);

    applyStimulus(1'b0, 1'b1, 7'd10, 16'hAAAA);
    applyStimulus(1'b1, 1'b1, 7'd10, 16'h5555);
    checkOutput("rbw_old", 32'(bus.o), 32'hAAAA);
    checkOutput("rbw_rvalid", 32'(bus.rvalid), 32'd1);
    applyStimulus(1'b1, 1'b0, 7'd10, '0);
    checkOutput("rbw_new", 32'(bus.o), 32'h5555);

    applyStimulus(1'b1, 1'b1, 7'd60, 16'h1234);
    checkOutput("rwDiff_setup", 32'(bus.o), 32'd256);
    applyStimulus(1'b1, 1'b1, 7'd45, 16'h0F0F);
    checkOutput("rwDiff_rd45", 32'(bus.o), 32'd64);
    applyStimulus(1'b1, 1'b0, 7'd60, '0);
    checkOutput("rwDiff_rd60", 32'(bus.o), 32'h1234);

    for (int k = 0; k < 400; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, 15)), DW'($urandom));
      checkCycle("rand");
    end

    // Reset inside READY, then again 40 cycles into the resulting clear.
    applyStimulus(1'b1, 1'b0, 7'd60, '0);
    rst = 1'b1;
    #2;
    checkOutput("rstReady_busy", 32'(bus.busy), 32'd1);
    checkOutput("rstReady_o", 32'(bus.o), 32'd0);
    checkOutput("rstReady_rvalid", 32'(bus.rvalid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.w = 1'b1;
    bus.addr = 7'd5;
    bus.D = 16'hFFFF;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("midClear_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    waitClear("clear2");

    applyStimulus(1'b1, 1'b0, 7'd5, '0);
    checkCycle("afterClear_a5");
    applyStimulus(1'b1, 1'b0, 7'd60, '0);
    checkCycle("afterClear_a60");
    applyStimulus(1'b1, 1'b0, 7'd10, '0);
    checkCycle("afterClear_a10");
    applyStimulus(1'b1, 1'b0, 7'd45, '0);
    checkCycle("afterClear_a45");

`ifdef RAM_SP_PARAM_PARITY_EN
    applyStimulus(1'b0, 1'b1, 7'd3, 16'h00F1);
    applyStimulus(1'b0, 1'b1, 7'd4, 16'h00F1);
    dut.mem[3][0] = ~dut.mem[3][0];
    applyStimulus(1'b1, 1'b0, 7'd3, '0);
    checkOutput("parity_bad_perr", 32'(bus.perr), 32'd1);
    checkOutput("parity_bad_rvalid", 32'(bus.rvalid), 32'd1);
    applyStimulus(1'b1, 1'b0, 7'd4, '0);
    checkOutput("parity_clean_perr", 32'(bus.perr), 32'd0);
    checkOutput("parity_clean_o", 32'(bus.o), 32'h00F1);
    applyStimulus(1'b0, 1'b0, 7'd3, '0);
    checkOutput("parity_idle_perr", 32'(bus.perr), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
